pcie_us_cfg_mgmt_target: RTL and testbench

- Target (responder) side of the UltraScale PCIe cfg_mgmt port, i.e. the end that fpga_core normally talks to inside the hard IP.
- Backs function 0 with a small soft configuration-space register file.
- Completes each read or write with a single-cycle read_write_done pulse after a programmable latency.
- Derives cfg_max_payload and cfg_max_read_req from the emulated Device Control register.
- Used for soft-endpoint simulation and as a cfg_mgmt stand-in during bring-up without the hard IP.

---
 rtl/pcie_cfg_pkg.sv | 32 +++
 rtl/pcie_us_cfg_mgmt_target_if.sv | 28 ++
 rtl/pcie_cfg_regfile.sv | 77 +++++++
 rtl/pcie_us_cfg_mgmt_target.sv | 122 ++++++++++++
 tb/tb_pcie_us_cfg_mgmt_target.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_cfg_pkg.sv
// Shared definitions for the soft cfg_mgmt target: FSM states, Device Control
// field positions, its reset constant and the per-dword write-mask rule.
package pcie_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned DEVCTL_OFFSET = 2;
   localparam int MPS_LSB  = 5;
   localparam int MPS_MSB  = 7;
   localparam int MRRS_LSB = 12;
   localparam int MRRS_MSB = 14;

   localparam logic [31:0] DEVCTL_RESET = 32'h0000_2810;

   // Identification dwords are read-only; header dword 1 and Device Control/Status
   // only expose their low halves to software.
   function automatic logic [31:0] writeMask(input logic [9:0] dw, input logic [9:0] capDw);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF;
      if (dw == 10'd0 || dw == 10'd2) begin
         mask = 32'h0000_0000;
      end else if (dw == 10'd1 || dw == (capDw + 10'(DEVCTL_OFFSET))) begin
         mask = 32'h0000_FFFF;
      end
      return mask;
   endfunction

endpackage

// File: rtl/pcie_us_cfg_mgmt_target_if.sv
// cfg_mgmt request/completion bundle plus the derived Device Control fields.
interface pcie_us_cfg_mgmt_target_if;

   logic [18:0] cfg_mgmt_addr;
   logic        cfg_mgmt_write;
   logic [31:0] cfg_mgmt_write_data;
   logic [3:0]  cfg_mgmt_byte_enable;
   logic        cfg_mgmt_read;
   logic [31:0] cfg_mgmt_read_data;
   logic        cfg_mgmt_read_write_done;
   logic [2:0]  cfg_max_payload;
   logic [2:0]  cfg_max_read_req;

   modport master (
      output cfg_mgmt_addr, cfg_mgmt_write, cfg_mgmt_write_data,
             cfg_mgmt_byte_enable, cfg_mgmt_read,
      input  cfg_mgmt_read_data, cfg_mgmt_read_write_done,
             cfg_max_payload, cfg_max_read_req
   );

   modport slave (
      input  cfg_mgmt_addr, cfg_mgmt_write, cfg_mgmt_write_data,
             cfg_mgmt_byte_enable, cfg_mgmt_read,
      output cfg_mgmt_read_data, cfg_mgmt_read_write_done,
             cfg_max_payload, cfg_max_read_req
   );

endinterface

// File: rtl/pcie_cfg_regfile.sv
// Soft configuration space for function 0: DEPTH dwords with async reset to
// identity values, masked byte-enable writes and a registered read port.
module pcie_cfg_regfile
   import pcie_cfg_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter logic [15:0] VENDOR_ID   = 16'h1234,
   parameter logic [15:0] DEVICE_ID   = 16'h0001,
   parameter logic [31:0] CLASS_REV   = 32'h0580_0000,
   parameter logic [7:0]  PCIE_CAP_DW = 8'h1C
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        commit_i,
   input  logic        isWrite_i,
   input  logic        hit_i,
   input  logic [9:0]  addr_i,
   input  logic [31:0] wrData_i,
   input  logic [3:0]  byteEn_i,
   output logic [31:0] rdData_o,
   output logic [2:0]  maxPayload_o,
   output logic [2:0]  maxReadReq_o
);

   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned DEVCTL_DW = 32'(PCIE_CAP_DW) + DEVCTL_OFFSET;
   localparam logic [AW-1:0] DEVCTL_IDX = AW'(DEVCTL_DW);

   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   rdData_q;
   logic [31:0]   bitMask_d;
   logic [AW-1:0] idx;

   function automatic logic [31:0] resetValue(input int unsigned dw);
      logic [31:0] value;
      value = 32'h0000_0000;
      if (dw == 0) begin
         value = {DEVICE_ID, VENDOR_ID};
      end else if (dw == 2) begin
         value = CLASS_REV;
      end else if (dw == DEVCTL_DW) begin
         value = DEVCTL_RESET;
      end
      return value;
   endfunction

   assign idx = addr_i[AW-1:0];

   always_comb begin
      bitMask_d = writeMask(addr_i, 10'(PCIE_CAP_DW)) &
                  {{8{byteEn_i[3]}}, {8{byteEn_i[2]}}, {8{byteEn_i[1]}}, {8{byteEn_i[0]}}};
   end

   // Callers only assert hit_i for in-range function-0 addresses, so idx is safe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= resetValue(i);
         end
      end else if (commit_i && isWrite_i && hit_i) begin
         mem_q[idx] <= (mem_q[idx] & ~bitMask_d) | (wrData_i & bitMask_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdData_q <= '0;
      end else if (commit_i) begin
         rdData_q <= (!isWrite_i && hit_i) ? mem_q[idx] : 32'h0000_0000;
      end
   end

   assign rdData_o     = rdData_q;
   assign maxPayload_o = mem_q[DEVCTL_IDX][MPS_MSB:MPS_LSB];
   assign maxReadReq_o = mem_q[DEVCTL_IDX][MRRS_MSB:MRRS_LSB];

endmodule

// File: rtl/pcie_us_cfg_mgmt_target.sv
// Responder end of the UltraScale cfg_mgmt port: accepts one request at a time,
// completes it after LATENCY cycles and mirrors MPS/MRRS out of Device Control.
module pcie_us_cfg_mgmt_target
   import pcie_cfg_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned LATENCY     = 2,
   parameter logic [15:0] VENDOR_ID   = 16'h1234,
   parameter logic [15:0] DEVICE_ID   = 16'h0001,
   parameter logic [31:0] CLASS_REV   = 32'h0580_0000,
   parameter logic [7:0]  PCIE_CAP_DW = 8'h1C
) (
   input logic                       clk,
   input logic                       rst,
   pcie_us_cfg_mgmt_target_if.slave  cfg
);

   localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

   state_e      state_q;
   logic [3:0]  count_q;
   logic [9:0]  addr_q;
   logic [7:0]  func_q;
   logic [31:0] wrData_q;
   logic [3:0]  byteEn_q;
   logic        isWrite_q;
   logic        done_q;
   logic [2:0]  maxPayload_q;
   logic [2:0]  maxReadReq_q;

   logic        commit;
   logic        hit;
   logic [2:0]  maxPayload_d;
   logic [2:0]  maxReadReq_d;
   logic        unusedAddrBit;

   assign unusedAddrBit = cfg.cfg_mgmt_addr[18];

   // The WAIT edge with an expired counter is the one that enters DONE.
   assign commit = (state_q == ST_WAIT) && (count_q == 4'd0);
   assign hit    = (func_q == 8'd0) && (32'(addr_q) < DEPTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         addr_q    <= '0;
         func_q    <= '0;
         wrData_q  <= '0;
         byteEn_q  <= '0;
         isWrite_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (cfg.cfg_mgmt_read || cfg.cfg_mgmt_write) begin
                  addr_q    <= cfg.cfg_mgmt_addr[9:0];
                  func_q    <= cfg.cfg_mgmt_addr[17:10];
                  wrData_q  <= cfg.cfg_mgmt_write_data;
                  byteEn_q  <= cfg.cfg_mgmt_byte_enable;
                  isWrite_q <= cfg.cfg_mgmt_write;
                  count_q   <= COUNT_INIT;
                  state_q   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (count_q == 4'd0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  count_q <= count_q - 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Re-registering the array fields makes them trail the committing write by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         maxPayload_q <= DEVCTL_RESET[MPS_MSB:MPS_LSB];
         maxReadReq_q <= DEVCTL_RESET[MRRS_MSB:MRRS_LSB];
      end else begin
         maxPayload_q <= maxPayload_d;
         maxReadReq_q <= maxReadReq_d;
      end
   end

   pcie_cfg_regfile #(
      .DEPTH       (DEPTH),
      .VENDOR_ID   (VENDOR_ID),
      .DEVICE_ID   (DEVICE_ID),
      .CLASS_REV   (CLASS_REV),
      .PCIE_CAP_DW (PCIE_CAP_DW)
   ) regFile (
      .clk          (clk),
      .rst          (rst),
      .commit_i     (commit),
      .isWrite_i    (isWrite_q),
      .hit_i        (hit),
      .addr_i       (addr_q),
      .wrData_i     (wrData_q),
      .byteEn_i     (byteEn_q),
      .rdData_o     (cfg.cfg_mgmt_read_data),
      .maxPayload_o (maxPayload_d),
      .maxReadReq_o (maxReadReq_d)
   );

   assign cfg.cfg_mgmt_read_write_done = done_q;
   assign cfg.cfg_max_payload          = maxPayload_q;
   assign cfg.cfg_max_read_req         = maxReadReq_q;

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_target.sv
// Bench for the soft cfg_mgmt target: directed scenarios plus random traffic
// compared against a dword-array model of the configuration space.
module tb_pcie_us_cfg_mgmt_target;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   pcie_us_cfg_mgmt_target_if bus ();
   pcie_us_cfg_mgmt_target_if bus1 ();
   pcie_us_cfg_mgmt_target_if bus15 ();

   pcie_us_cfg_mgmt_target dut (.clk(clk), .rst(rst), .cfg(bus.slave));
   pcie_us_cfg_mgmt_target #(.LATENCY(1))  dut1  (.clk(clk), .rst(rst), .cfg(bus1.slave));
   pcie_us_cfg_mgmt_target #(.LATENCY(15)) dut15 (.clk(clk), .rst(rst), .cfg(bus15.slave));

   int checks   = 0;
   int failures = 0;

   logic [31:0] model [64];

   // Reference configuration space, built from the documented reset contents.
   function automatic void modelReset();
      for (int i = 0; i < 64; i++) model[i] = 32'h0;
      model[0]  = 32'h0001_1234;
      model[2]  = 32'h0580_0000;
      model[30] = 32'h0000_2810;
   endfunction

   function automatic logic [31:0] modelRead(input logic [18:0] a);
      int dw;
      dw = int'(a[9:0]);
      if (a[17:10] != 8'd0 || dw >= 64) return 32'h0;
      return model[dw];
   endfunction

   function automatic void modelWrite(input logic [18:0] a, input logic [31:0] d, input logic [3:0] be);
      int dw;
      bit laneOk;
      dw = int'(a[9:0]);
      if (a[17:10] != 8'd0 || dw >= 64) return;
      for (int b = 0; b < 4; b++) begin
         laneOk = be[b];
         if (dw == 0 || dw == 2) laneOk = 1'b0;
         if ((dw == 1 || dw == 30) && b >= 2) laneOk = 1'b0;
         if (laneOk) model[dw][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   // Drives one request on the main port; caller sits just after a clock edge with the DUT idle.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [18:0] addr,
                                input logic [31:0] data, input logic [3:0] be,
                                output logic [31:0] rdata, output int lat,
                                output logic pulseOk, output logic [2:0] mrrsAtDone);
      bus.cfg_mgmt_addr        = addr;
      bus.cfg_mgmt_write_data  = data;
      bus.cfg_mgmt_byte_enable = be;
      bus.cfg_mgmt_read        = rd;
      bus.cfg_mgmt_write       = wr;
      @(posedge clk);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (bus.cfg_mgmt_read_write_done !== 1'b1 && lat < 40);
      rdata      = bus.cfg_mgmt_read_data;
      mrrsAtDone = bus.cfg_max_read_req;
      bus.cfg_mgmt_read  = 1'b0;
      bus.cfg_mgmt_write = 1'b0;
      @(posedge clk);
      #1;
      pulseOk = (bus.cfg_mgmt_read_write_done === 1'b0);
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      checks++;
      if (bus.cfg_mgmt_read_write_done !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_done: got %b expected 0", bus.cfg_mgmt_read_write_done);
      end
      checks++;
      if (bus.cfg_mgmt_read_data !== 32'h0) begin
         failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.cfg_mgmt_read_data);
      end
      checks++;
      if (bus.cfg_max_payload !== 3'd0) begin
         failures++; $display("[TB] FAIL reset_mps: got %0d expected 0", bus.cfg_max_payload);
      end
      checks++;
      if (bus.cfg_max_read_req !== 3'd2) begin
         failures++; $display("[TB] FAIL reset_mrrs: got %0d expected 2", bus.cfg_max_read_req);
      end
      rst = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_read_id();
      logic [31:0] rdata; int lat; logic pulseOk; logic [2:0] mrrs;
      applyStimulus(1'b1, 1'b0, 19'd0, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (lat != 2) begin failures++; $display("[TB] FAIL read0_latency: got %0d expected 2", lat); end
      checks++;
      if (rdata !== 32'h0001_1234) begin failures++; $display("[TB] FAIL read0_data: got %h expected 00011234", rdata); end
      checks++;
      if (pulseOk !== 1'b1) begin failures++; $display("[TB] FAIL read0_single_pulse: got done still high expected low"); end
      applyStimulus(1'b1, 1'b0, 19'd2, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h0580_0000) begin failures++; $display("[TB] FAIL read2_data: got %h expected 05800000", rdata); end
   endtask

   task automatic test_devctl();
      logic [31:0] rdata; int lat; logic pulseOk; logic [2:0] mrrs;
      applyStimulus(1'b0, 1'b1, 19'h1E, 32'hFFFF_70A0, 4'hF, rdata, lat, pulseOk, mrrs);
      modelWrite(19'h1E, 32'hFFFF_70A0, 4'hF);
      checks++;
      if (mrrs !== 3'd2) begin failures++; $display("[TB] FAIL devctl_mrrs_at_done: got %0d expected 2", mrrs); end
      checks++;
      if (bus.cfg_max_payload !== 3'd5) begin failures++; $display("[TB] FAIL devctl_mps: got %0d expected 5", bus.cfg_max_payload); end
      checks++;
      if (bus.cfg_max_read_req !== 3'd7) begin failures++; $display("[TB] FAIL devctl_mrrs: got %0d expected 7", bus.cfg_max_read_req); end
      applyStimulus(1'b1, 1'b0, 19'h1E, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h0000_70A0) begin failures++; $display("[TB] FAIL devctl_readback: got %h expected 000070A0", rdata); end
   endtask

   task automatic test_masks();
      logic [31:0] rdata; int lat; logic pulseOk; logic [2:0] mrrs;
      applyStimulus(1'b0, 1'b1, 19'd0, 32'hDEAD_BEEF, 4'hF, rdata, lat, pulseOk, mrrs);
      applyStimulus(1'b1, 1'b0, 19'd0, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h0001_1234) begin failures++; $display("[TB] FAIL ro_dword0: got %h expected 00011234", rdata); end
      applyStimulus(1'b0, 1'b1, 19'd5, 32'hAABB_CCDD, 4'b0101, rdata, lat, pulseOk, mrrs);
      modelWrite(19'd5, 32'hAABB_CCDD, 4'b0101);
      applyStimulus(1'b1, 1'b0, 19'd5, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h00BB_00DD) begin failures++; $display("[TB] FAIL byte_enable_0101: got %h expected 00BB00DD", rdata); end
      applyStimulus(1'b0, 1'b1, 19'd5, 32'h1111_1111, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (lat != 2 || pulseOk !== 1'b1) begin failures++; $display("[TB] FAIL be_zero_done: got latency %0d pulse %b expected 2 1", lat, pulseOk); end
      applyStimulus(1'b1, 1'b0, 19'd5, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h00BB_00DD) begin failures++; $display("[TB] FAIL be_zero_nochange: got %h expected 00BB00DD", rdata); end
      applyStimulus(1'b0, 1'b1, 19'd1, 32'hFFFF_FFFF, 4'hF, rdata, lat, pulseOk, mrrs);
      modelWrite(19'd1, 32'hFFFF_FFFF, 4'hF);
      applyStimulus(1'b1, 1'b0, 19'd1, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h0000_FFFF) begin failures++; $display("[TB] FAIL dword1_mask: got %h expected 0000FFFF", rdata); end
   endtask

   task automatic test_outside();
      logic [31:0] rdata; int lat; logic pulseOk; logic [2:0] mrrs;
      logic [18:0] a;
      a = {1'b0, 8'd3, 10'd0};
      applyStimulus(1'b1, 1'b0, a, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h0 || pulseOk !== 1'b1) begin failures++; $display("[TB] FAIL func3_read: got %h pulse %b expected 0 1", rdata, pulseOk); end
      applyStimulus(1'b0, 1'b1, 19'd64, 32'h5555_5555, 4'hF, rdata, lat, pulseOk, mrrs);
      applyStimulus(1'b1, 1'b0, 19'd64, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h0 || pulseOk !== 1'b1) begin failures++; $display("[TB] FAIL dword64_read: got %h pulse %b expected 0 1", rdata, pulseOk); end
      a = {1'b0, 8'd3, 10'd5};
      applyStimulus(1'b0, 1'b1, a, 32'h7777_7777, 4'hF, rdata, lat, pulseOk, mrrs);
      applyStimulus(1'b1, 1'b0, 19'd5, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== modelRead(19'd5)) begin failures++; $display("[TB] FAIL func3_write_dropped: got %h expected %h", rdata, modelRead(19'd5)); end
   endtask

   task automatic test_rw_both();
      logic [31:0] rdata; int lat; logic pulseOk; logic [2:0] mrrs;
      applyStimulus(1'b1, 1'b1, 19'd5, 32'h1234_5678, 4'hF, rdata, lat, pulseOk, mrrs);
      modelWrite(19'd5, 32'h1234_5678, 4'hF);
      checks++;
      if (rdata !== 32'h0 || pulseOk !== 1'b1 || lat != 2) begin
         failures++; $display("[TB] FAIL rw_both_completion: got data %h pulse %b latency %0d expected 0 1 2", rdata, pulseOk, lat);
      end
      applyStimulus(1'b1, 1'b0, 19'd5, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL rw_both_write_applied: got %h expected 12345678", rdata); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rdata; int lat; logic pulseOk; logic [2:0] mrrs;
      logic [31:0] expData;
      logic [18:0] a;
      logic [7:0] func;
      logic rd, wr;
      int op, dw;
      for (int n = 0; n < 60; n++) begin
         op   = int'($urandom_range(0, 3));
         rd   = (op != 1);
         wr   = (op == 1 || op == 2);
         dw   = int'($urandom_range(0, 69));
         if (dw < 40 && $urandom_range(0, 1) == 1) dw = 30;
         func = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         a    = {1'($urandom_range(0, 1)), func, 10'(dw)};
         expData = wr ? 32'h0 : modelRead(a);
         applyStimulus(rd, wr, a, $urandom, 4'($urandom_range(0, 15)), rdata, lat, pulseOk, mrrs);
         if (wr) modelWrite(a, bus.cfg_mgmt_write_data, bus.cfg_mgmt_byte_enable);
         checks++;
         if (lat != 2 || pulseOk !== 1'b1) begin
            failures++; $display("[TB] FAIL rand_timing[%0d]: got latency %0d pulse %b expected 2 1", n, lat, pulseOk);
         end
         checks++;
         if (rdata !== expData) begin
            failures++; $display("[TB] FAIL rand_data[%0d] addr %h: got %h expected %h", n, a, rdata, expData);
         end
         checks++;
         if (bus.cfg_max_payload !== model[30][7:5] || bus.cfg_max_read_req !== model[30][14:12]) begin
            failures++; $display("[TB] FAIL rand_devctl[%0d]: got mps %0d mrrs %0d expected %0d %0d", n,
                                 bus.cfg_max_payload, bus.cfg_max_read_req, model[30][7:5], model[30][14:12]);
         end
      end
   endtask

   task automatic test_latency();
      int n, expLat;
      logic d;
      logic [31:0] rdata;
      for (int k = 0; k < 2; k++) begin
         expLat = (k == 0) ? 1 : 15;
         if (k == 0) bus1.cfg_mgmt_read = 1'b1;
         else        bus15.cfg_mgmt_read = 1'b1;
         @(posedge clk);
         n = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
            d = (k == 0) ? bus1.cfg_mgmt_read_write_done : bus15.cfg_mgmt_read_write_done;
         end while (d !== 1'b1 && n < 40);
         rdata = (k == 0) ? bus1.cfg_mgmt_read_data : bus15.cfg_mgmt_read_data;
         bus1.cfg_mgmt_read  = 1'b0;
         bus15.cfg_mgmt_read = 1'b0;
         checks++;
         if (n != expLat) begin failures++; $display("[TB] FAIL latency_build_%0d: got %0d expected %0d", expLat, n, expLat); end
         checks++;
         if (rdata !== 32'h0001_1234) begin failures++; $display("[TB] FAIL latency_build_%0d_data: got %h expected 00011234", expLat, rdata); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rdata; int lat; logic pulseOk; logic [2:0] mrrs;
      bus.cfg_mgmt_addr        = 19'h1E;
      bus.cfg_mgmt_write_data  = 32'h0000_5040;
      bus.cfg_mgmt_byte_enable = 4'hF;
      bus.cfg_mgmt_write       = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      bus.cfg_mgmt_write = 1'b0;
      checks++;
      if (bus.cfg_max_read_req !== 3'd2) begin failures++; $display("[TB] FAIL midreset_mrrs: got %0d expected 2", bus.cfg_max_read_req); end
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (bus.cfg_mgmt_read_write_done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_no_done: got %b expected 0", bus.cfg_mgmt_read_write_done); end
      rst = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 19'h1E, 32'h0, 4'h0, rdata, lat, pulseOk, mrrs);
      checks++;
      if (rdata !== 32'h0000_2810) begin failures++; $display("[TB] FAIL midreset_readback: got %h expected 00002810", rdata); end
      checks++;
      if (bus.cfg_max_read_req !== 3'd2) begin failures++; $display("[TB] FAIL midreset_mrrs_after: got %0d expected 2", bus.cfg_max_read_req); end
   endtask

   initial begin
      bus.cfg_mgmt_addr = '0;   bus.cfg_mgmt_write = 1'b0;   bus.cfg_mgmt_write_data = '0;
      bus.cfg_mgmt_byte_enable = '0;   bus.cfg_mgmt_read = 1'b0;
      bus1.cfg_mgmt_addr = '0;  bus1.cfg_mgmt_write = 1'b0;  bus1.cfg_mgmt_write_data = '0;
      bus1.cfg_mgmt_byte_enable = '0;  bus1.cfg_mgmt_read = 1'b0;
      bus15.cfg_mgmt_addr = '0; bus15.cfg_mgmt_write = 1'b0; bus15.cfg_mgmt_write_data = '0;
      bus15.cfg_mgmt_byte_enable = '0; bus15.cfg_mgmt_read = 1'b0;
      modelReset();
      test_reset();
      test_read_id();
      test_devctl();
      test_masks();
      test_outside();
      test_rw_both();
      test_back_to_back();
      test_latency();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
